// File: rtl/seg_pkg.sv
// Shared codes, segment patterns and scan-state encoding for the seven-segment scanner.
// Segment bit order is {g,f,e,d,c,b,a}, active high.
package seg_pkg;

  localparam logic [4:0] CODE_BLANK = 5'h10;
  localparam logic [4:0] CODE_DASH  = 5'h11;

  localparam logic [6:0] SEG_BLANK  = 7'h00;
  localparam logic [6:0] SEG_DASH   = 7'h40;

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      4'hF:    seg = 7'h71;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_decoder.sv
// Maps a 6-bit display code to a segment pattern: 0x00-0x0F hex, 0x11 dash,
// every other code blank.
module seg_decoder
  import seg_pkg::*;
(
  input  logic [5:0] i_code,
  output logic [6:0] o_seg
);

  // Pure lookup; the caller registers the code, so this stays combinational.
  always_comb begin
    o_seg = SEG_BLANK;
    if (i_code[5:4] == 2'b00) begin
      o_seg = hex_to_seg(i_code[3:0]);
    end else if (i_code == {1'b0, CODE_DASH}) begin
      o_seg = SEG_DASH;
    end else begin
      o_seg = SEG_BLANK;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with a pending/active frame buffer pair.
// Build macro SEG_LZ_SUPPRESS_EN blanks leading zero digits when a frame goes live.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 6,
  parameter int SLOT_CYCLES  = 50000,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    scan_en,
  input  logic                    upd_valid,
  output logic                    upd_ready,
  input  logic [5*NUM_DIGITS-1:0] upd_codes,
  output logic [6:0]              seg_data,
  output logic [NUM_DIGITS-1:0]   dig_sel_n,
  output logic                    frame_done
);

  localparam int PW = $clog2(SLOT_CYCLES);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int BW = 5 * NUM_DIGITS;

  localparam logic [PW-1:0] PRESC_LAST  = PW'(SLOT_CYCLES - 1);
  localparam logic [PW-1:0] PRESC_GUARD = PW'(GUARD_CYCLES);
  localparam logic [IW-1:0] IDX_LAST    = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]         r_presc;
  logic [IW-1:0]         r_idx;
  scan_state_e           r_state;
  logic [BW-1:0]         r_pend;
  logic [BW-1:0]         r_active;
  logic                  r_upd_ready;
  logic [5:0]            r_code;
  logic [NUM_DIGITS-1:0] r_dig_sel_n;
  logic                  r_frame_done;

  logic [PW-1:0]         w_presc_next;
  logic [IW-1:0]         w_idx_next;
  scan_state_e           w_state_next;
  logic                  w_slot_end;
  logic                  w_frame_wrap;
  logic                  w_accept;
  logic                  w_copy;
  logic [BW-1:0]         w_pend_proc;
  logic [BW-1:0]         w_active_next;
  logic [4:0]            w_code_sel;
  logic [NUM_DIGITS-1:0] w_dig_sel_n_next;
  logic                  w_frame_done_next;
  logic [6:0]            w_seg;

  assign w_slot_end   = (r_presc == PRESC_LAST);
  assign w_frame_wrap = scan_en && w_slot_end && (r_idx == IDX_LAST);
  assign w_accept     = upd_valid && r_upd_ready;
  // A full pending buffer is exactly the not-ready condition.
  assign w_copy       = w_frame_wrap && !r_upd_ready;

`ifdef SEG_LZ_SUPPRESS_EN
  function automatic logic [BW-1:0] lz_suppress(input logic [BW-1:0] codes);
    logic [BW-1:0] res;
    logic          seen;
    res  = codes;
    seen = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (!seen && (codes[5*i +: 5] == 5'h00)) begin
        res[5*i +: 5] = CODE_BLANK;
      end else if (codes[5*i +: 5] <= 5'h0F) begin
        seen = 1'b1;
      end else begin
        seen = seen;
      end
    end
    return res;
  endfunction

  assign w_pend_proc = lz_suppress(r_pend);
`else
  assign w_pend_proc = r_pend;
`endif

  assign w_active_next = w_copy ? w_pend_proc : r_active;

  // Scan state register: prescaler, digit index and slot phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_state <= ST_GUARD;
    end else begin
      r_presc <= w_presc_next;
      r_idx   <= w_idx_next;
      r_state <= w_state_next;
    end
  end

  // Next-state logic; everything freezes while scanning is disabled.
  always_comb begin
    w_presc_next = r_presc;
    w_idx_next   = r_idx;
    w_state_next = r_state;
    if (scan_en) begin
      if (w_slot_end) begin
        w_presc_next = '0;
        w_idx_next   = (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
      end else begin
        w_presc_next = r_presc + PW'(1);
        w_idx_next   = r_idx;
      end
    end else begin
      w_presc_next = r_presc;
      w_idx_next   = r_idx;
    end
    case (r_state)
      ST_GUARD: begin
        if (w_presc_next >= PRESC_GUARD) w_state_next = ST_DRIVE;
        else                             w_state_next = ST_GUARD;
      end
      ST_DRIVE: begin
        if (w_presc_next < PRESC_GUARD) w_state_next = ST_GUARD;
        else                            w_state_next = ST_DRIVE;
      end
      default: w_state_next = ST_GUARD;
    endcase
  end

  // Output decode of the next state, registered below so outputs track the state.
  always_comb begin
    w_dig_sel_n_next = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_en && (w_state_next == ST_DRIVE) && (w_idx_next == IW'(i))) begin
        w_dig_sel_n_next[i] = 1'b0;
      end else begin
        w_dig_sel_n_next[i] = 1'b1;
      end
    end
    w_frame_done_next = scan_en && (w_presc_next == PRESC_LAST) && (w_idx_next == IDX_LAST);
  end

  // Registered digit select and frame pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dig_sel_n  <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_dig_sel_n  <= w_dig_sel_n_next;
      r_frame_done <= w_frame_done_next;
    end
  end

  // Pending/active frame buffers and the update handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend      <= '0;
      r_active    <= {NUM_DIGITS{CODE_BLANK}};
      r_upd_ready <= 1'b1;
    end else begin
      if (w_accept) begin
        r_pend      <= upd_codes;
        r_upd_ready <= 1'b0;
      end else if (w_copy) begin
        r_upd_ready <= 1'b1;
      end else begin
        r_upd_ready <= r_upd_ready;
      end
      r_active <= w_active_next;
    end
  end

  // Code for the digit about to be scanned, taken from the post-copy buffer.
  always_comb begin
    w_code_sel = CODE_BLANK;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_idx_next == IW'(i)) begin
        w_code_sel = w_active_next[5*i +: 5];
      end else begin
        w_code_sel = w_code_sel;
      end
    end
  end

  // Decoder code only moves on entry to a new slot, i.e. inside the dark guard time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_code <= {1'b0, CODE_BLANK};
    end else if (scan_en && w_slot_end) begin
      r_code <= {1'b0, w_code_sel};
    end else begin
      r_code <= r_code;
    end
  end

  seg_decoder u_seg_decoder (
    .i_code (r_code),
    .o_seg  (w_seg)
  );

  assign seg_data   = w_seg;
  assign dig_sel_n  = r_dig_sel_n;
  assign frame_done = r_frame_done;
  assign upd_ready  = r_upd_ready;

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 6, number of multiplexed digits (2..8).
REQ-002 SHALL have parameter SLOT_CYCLES, default 50000, clocks per digit slot (>= GUARD_CYCLES+2).
REQ-003 SHALL have parameter GUARD_CYCLES, default 2, dark clocks at start of each slot (de-ghosting).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port scan_en  input  1  scan enable; low blanks all digits and freezes counters.
REQ-007 SHALL have port upd_valid  input  1  new frame offered.
REQ-008 SHALL have port upd_ready  output  1  controller can accept a frame.
REQ-009 SHALL have port upd_codes  input  5*NUM_DIGITS  per-digit codes, digit 0 in bits [4:0]; 0x00-0x0F hex, 0x10 blank, 0x11 dash.
REQ-010 SHALL have port seg_data  output  7  segment pattern for the currently selected digit.
REQ-011 SHALL have port dig_sel_n  output  NUM_DIGITS  active-low one-hot digit select.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse at end of the last digit slot.

Function
REQ-013 SHALL accept upd_codes into a pending buffer on any cycle with upd_valid && upd_ready, then deassert upd_ready until the pending buffer is consumed.
REQ-014 SHALL copy the pending buffer to the active buffer at a frame boundary (last cycle of slot NUM_DIGITS-1), reasserting upd_ready the following cycle; no mid-frame change of displayed data.
REQ-015 SHALL, when an accept and a frame boundary coincide, keep the new frame pending until the next boundary.
REQ-016 SHALL count a prescaler 0..SLOT_CYCLES-1, wrapping to 0 and advancing the digit index 0..NUM_DIGITS-1, which wraps to 0.
REQ-017 SHALL run state machine per slot: GUARD (prescaler < GUARD_CYCLES, dig_sel_n all ones) -> DRIVE (dig_sel_n bit[index] low) -> GUARD of the next slot.
REQ-018 SHALL register the 6-bit decoder code (zero-extended active code for the current index) so that seg_data changes on the first GUARD cycle of a slot, never during DRIVE.
REQ-019 SHALL pulse frame_done for exactly one cycle, concurrent with the frame boundary.
REQ-020 SHALL, with scan_en low, force dig_sel_n to all ones and hold prescaler, index and state; upd handshake remains operational; on re-enable, resume from the held point.
REQ-021 SHALL treat codes 0x12-0x1F as blank.

Reset
REQ-022 SHALL on rst: prescaler 0, index 0, state GUARD, active buffer all 0x10, pending empty, upd_ready 1, dig_sel_n all ones, frame_done 0, seg_data = blank pattern.
REQ-023 SHALL on rst mid-frame discard any pending frame and restart from digit 0.

Configuration
REQ-024 SHALL, when SEG_LZ_SUPPRESS_EN is defined, replace each 0x00 code above the highest-indexed non-zero hex digit with 0x10 at copy-to-active time; digit 0 is never suppressed.
REQ-025 SHALL, without SEG_LZ_SUPPRESS_EN, display all codes unmodified.

Structure
REQ-026 SHALL place CODE_BLANK (0x10), CODE_DASH (0x11) and the GUARD/DRIVE state enum in shared package seg_pkg.
REQ-027 SHALL instantiate exactly one seg_decoder sub-module, shared across all digits.

Verification (NUM_DIGITS=4, SLOT_CYCLES=8, GUARD_CYCLES=2)
REQ-028 SHALL cover: reset release, scan_en=1 -> dig_sel_n cycles 1111,1111,1110x6,1111x2,1101x6..., all digits blank pattern, frame_done every 32 cycles.
REQ-029 SHALL cover: upd_codes={0x3,0x2,0x1,0x0} accepted mid-frame -> upd_ready low, old data until boundary, digits 0..3 show 0,1,2,3 from next frame.
REQ-030 SHALL cover: upd_valid on boundary cycle -> frame held pending one further frame, upd_ready low throughout.
REQ-031 SHALL cover: scan_en low for 10 cycles in DRIVE of digit 2 -> dig_sel_n=1111, then resumes digit 2 with remaining DRIVE cycles.
REQ-032 SHALL cover: with SEG_LZ_SUPPRESS_EN, codes {0x0,0x0,0x5,0x0} -> digits 3,2 blank, digit 1 shows 5, digit 0 shows 0; codes all 0x0 -> only digit 0 shows 0.
REQ-033 SHALL cover: rst asserted mid-slot of digit 3 with pending frame -> all outputs at reset values immediately, pending frame discarded.
